// File: rtl/stack_seq_pkg.sv
// Shared definitions for the operand-stack sequencer: opcodes, FSM states,
// per-op operand/depth constants and the ALU step.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    OP_PUSHI = 3'd0,
    OP_POP   = 3'd1,
    OP_DUP   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_AND   = 3'd5,
    OP_NOT   = 3'd6,
    OP_SWAP  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_POP2,
    S_TOS1,
    S_WAIT,
    S_PUSH1,
    S_PUSH2,
    S_DONE
  } state_e;

  localparam int ALU_W = 64;

  function automatic logic [1:0] op_needs(op_e op);
    case (op)
      OP_PUSHI:               return 2'd0;
      OP_POP, OP_DUP, OP_NOT: return 2'd1;
      default:                return 2'd2;
    endcase
  endfunction

  function automatic logic signed [1:0] op_delta(op_e op);
    case (op)
      OP_PUSHI, OP_DUP: return 2'sb01;
      OP_NOT, OP_SWAP:  return 2'sb00;
      default:          return 2'sb11;
    endcase
  endfunction

  // Works on a wide word; callers truncate to their own data width,
  // which keeps the wrap-around arithmetic modulo 2^WIDTH.
  function automatic logic [ALU_W-1:0] alu(op_e op, logic [ALU_W-1:0] b,
                                           logic [ALU_W-1:0] a);
    case (op)
      OP_ADD:  return b + a;
      OP_SUB:  return b - a;
      OP_AND:  return b & a;
      OP_NOT:  return ~b;
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Request/response and stack-port bundle between a client and the sequencer.
interface stack_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] imm;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] res;
  logic [DW-1:0]    depth;
  logic             stk_push;
  logic             stk_pop;
  logic             stk_tos;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;

  modport master (
    output start, op, imm, stk_dout,
    input  busy, done, err, res, depth, stk_push, stk_pop, stk_tos, stk_din
  );

  modport slave (
    input  start, op, imm, stk_dout,
    output busy, done, err, res, depth, stk_push, stk_pop, stk_tos, stk_din
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Sequences one stack-machine operation per start into pop/tos/push strobes,
// tracking occupancy so underflow/overflow never reach the stack.
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  stack_op_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);

  state_e           state;
  state_e           next;
  op_e              op_q;
  op_e              op_in;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] din;
  logic [DW-1:0]    depth_q;
  logic             err_q;
  logic             precheck_fail;

  assign op_in = op_e'(bus.op);

  always_comb begin
    precheck_fail = (depth_q < DW'(op_needs(op_in))) ||
                    ((op_delta(op_in) == 2'sb01) && (depth_q == DW'(DEPTH)));
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (precheck_fail) next = S_DONE;
          else begin
            case (op_in)
              OP_PUSHI: next = S_PUSH1;
              OP_DUP:   next = S_TOS1;
              default:  next = S_POP1;
            endcase
          end
        end
      end
      S_POP1: begin
        case (op_q)
          OP_POP:  next = S_WAIT;
          OP_NOT:  next = S_PUSH1;
          default: next = S_POP2;
        endcase
      end
      S_POP2:  next = S_PUSH1;
      S_TOS1:  next = S_PUSH1;
      S_WAIT:  next = S_DONE;
      S_PUSH1: next = (op_q == OP_SWAP) ? S_PUSH2 : S_DONE;
      S_PUSH2: next = S_DONE;
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // The second operand only appears on stk_dout during PUSH1, so push data
  // that depends on it is taken straight from the stack output in that cycle.
  always_comb begin
    din = '0;
    if (state == S_PUSH1) begin
      case (op_q)
        OP_PUSHI: din = imm_q;
        OP_DUP:   din = bus.stk_dout;
        OP_SWAP:  din = a_q;
        default:  din = WIDTH'(alu(op_q, ALU_W'(bus.stk_dout), ALU_W'(a_q)));
      endcase
    end else if (state == S_PUSH2) begin
      din = b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q    <= OP_PUSHI;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        op_q  <= op_in;
        imm_q <= bus.imm;
        err_q <= precheck_fail;
      end
      if (state == S_POP2) a_q <= bus.stk_dout;
      if (state == S_PUSH1 && op_q == OP_SWAP) b_q <= bus.stk_dout;
      if (state == S_WAIT) res_q <= bus.stk_dout;
      if ((state == S_PUSH1 && op_q != OP_SWAP) || state == S_PUSH2) res_q <= din;
      if (bus.stk_push)     depth_q <= depth_q + DW'(1);
      else if (bus.stk_pop) depth_q <= depth_q - DW'(1);
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.err      = (state == S_DONE) && err_q;
  assign bus.res      = res_q;
  assign bus.depth    = depth_q;
  assign bus.stk_push = (state == S_PUSH1) || (state == S_PUSH2);
  assign bus.stk_pop  = (state == S_POP1) || (state == S_POP2);
  assign bus.stk_tos  = (state == S_TOS1);
  assign bus.stk_din  = din;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench: behavioural operand stack plus a reference model that
// queues expected results per operation for comparison at done.
module tb_stack_op_sequencer;
  import stack_seq_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [3:0]  depth;
    int          lat;
    int          pu;
    int          po;
    int          tos;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  stack_op_sequencer_if #(.WIDTH(16), .DEPTH(8)) bus ();

  stack_op_sequencer #(.WIDTH(16), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [8];
  int          sp;
  logic [15:0] dout;
  int          n_push = 0;
  int          n_pop = 0;
  int          n_tos = 0;
  int          n_multi = 0;

  assign bus.stk_dout = dout;

  always @(posedge clk) begin
    if (!rst) begin
      sp   <= 0;
      dout <= '0;
    end else begin
      if (bus.stk_pop && sp > 0) begin
        dout <= mem[sp-1];
        sp   <= sp - 1;
      end else if (bus.stk_tos && sp > 0) begin
        dout <= mem[sp-1];
      end else if (bus.stk_push && sp < 8) begin
        mem[sp] <= bus.stk_din;
        sp      <= sp + 1;
      end
      n_push <= n_push + int'(bus.stk_push);
      n_pop  <= n_pop + int'(bus.stk_pop);
      n_tos  <= n_tos + int'(bus.stk_tos);
      if (int'(bus.stk_push) + int'(bus.stk_pop) + int'(bus.stk_tos) > 1) n_multi <= n_multi + 1;
    end
  end

  logic [15:0] rs[$];
  logic [15:0] exp_res;
  rec_t        sb_q[$];
  rec_t        obs_q[$];

  task automatic do_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rs.delete();
    exp_res = '0;
  endtask

  // Updates the reference stack, queues the expectation, then drives one
  // operation and records what the DUT reported at done.
  task automatic issue_op(input logic [2:0] op, input logic [15:0] imm);
    rec_t e;
    rec_t o;
    int need, p0, q0, t0;
    logic [15:0] a, b;
    need = (op == OP_PUSHI) ? 0 : (op == OP_POP || op == OP_DUP || op == OP_NOT) ? 1 : 2;
    e.pu = 0; e.po = 0; e.tos = 0; e.err = 1'b0; e.lat = 1;
    if (rs.size() < need || ((op == OP_PUSHI || op == OP_DUP) && rs.size() == 8)) begin
      e.err = 1'b1;
    end else begin
      case (op)
        OP_PUSHI: begin rs.push_back(imm); exp_res = imm; e.lat = 2; e.pu = 1; end
        OP_POP:   begin exp_res = rs.pop_back(); e.lat = 3; e.po = 1; end
        OP_DUP:   begin exp_res = rs[rs.size()-1]; rs.push_back(exp_res); e.lat = 3; e.pu = 1; e.tos = 1; end
        OP_NOT:   begin a = rs.pop_back(); exp_res = ~a; rs.push_back(exp_res); e.lat = 3; e.pu = 1; e.po = 1; end
        OP_SWAP:  begin
          a = rs.pop_back(); b = rs.pop_back();
          rs.push_back(a); rs.push_back(b);
          exp_res = b; e.lat = 5; e.pu = 2; e.po = 2;
        end
        default:  begin
          a = rs.pop_back(); b = rs.pop_back();
          exp_res = (op == OP_ADD) ? b + a : (op == OP_SUB) ? b - a : b & a;
          rs.push_back(exp_res); e.lat = 4; e.pu = 1; e.po = 2;
        end
      endcase
    end
    e.res = exp_res;
    e.depth = 4'(rs.size());
    sb_q.push_back(e);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.imm   = imm;
    p0 = n_push; q0 = n_pop; t0 = n_tos;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.imm   = 16'($urandom);
    o.lat = 0;
    while (o.lat < 20) begin
      @(negedge clk);
      o.lat++;
      if (bus.done) break;
    end
    o.res = bus.res; o.err = bus.err; o.depth = bus.depth;
    o.pu = n_push - p0; o.po = n_pop - q0; o.tos = n_tos - t0;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if ({bus.stk_push, bus.stk_pop, bus.stk_tos} !== 3'b000) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 000", {bus.stk_push, bus.stk_pop, bus.stk_tos}); end
    checks++; if (bus.res !== 16'h0) begin errors++; $display("[TB] FAIL reset_res: got %h expected 0000", bus.res); end
    checks++; if (bus.stk_din !== 16'h0) begin errors++; $display("[TB] FAIL reset_din: got %h expected 0000", bus.stk_din); end
    checks++; if (bus.depth !== 4'd0) begin errors++; $display("[TB] FAIL reset_depth: got %0d expected 0", bus.depth); end
    rst = 1'b1;
    rs.delete();
    exp_res = '0;
  endtask

  task automatic test_add();
    rec_t e, o;
    do_reset();
    issue_op(OP_PUSHI, 16'd5);
    issue_op(OP_PUSHI, 16'd3);
    issue_op(OP_ADD, 16'hDEAD);
    for (int i = 0; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.res !== e.res) begin errors++; $display("[TB] FAIL add_res[%0d]: got %h expected %h", i, o.res, e.res); end
      checks++; if (o.err !== e.err) begin errors++; $display("[TB] FAIL add_err[%0d]: got %b expected %b", i, o.err, e.err); end
      checks++; if (o.depth !== e.depth) begin errors++; $display("[TB] FAIL add_depth[%0d]: got %0d expected %0d", i, o.depth, e.depth); end
      checks++; if (o.lat != e.lat) begin errors++; $display("[TB] FAIL add_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat); end
      checks++; if (o.pu != e.pu || o.po != e.po || o.tos != e.tos) begin errors++; $display("[TB] FAIL add_strobes[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, o.pu, o.po, o.tos, e.pu, e.po, e.tos); end
    end
  endtask

  task automatic test_sub_not();
    rec_t e, o;
    do_reset();
    issue_op(OP_PUSHI, 16'd3);
    issue_op(OP_PUSHI, 16'd5);
    issue_op(OP_SUB, 16'h0);
    issue_op(OP_NOT, 16'h0);
    issue_op(OP_PUSHI, 16'hF0F0);
    issue_op(OP_PUSHI, 16'h3C3C);
    issue_op(OP_AND, 16'h0);
    for (int i = 0; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.res !== e.res) begin errors++; $display("[TB] FAIL alu_res[%0d]: got %h expected %h", i, o.res, e.res); end
      checks++; if (o.err !== e.err) begin errors++; $display("[TB] FAIL alu_err[%0d]: got %b expected %b", i, o.err, e.err); end
      checks++; if (o.depth !== e.depth) begin errors++; $display("[TB] FAIL alu_depth[%0d]: got %0d expected %0d", i, o.depth, e.depth); end
      checks++; if (o.lat != e.lat) begin errors++; $display("[TB] FAIL alu_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat); end
      checks++; if (o.pu != e.pu || o.po != e.po || o.tos != e.tos) begin errors++; $display("[TB] FAIL alu_strobes[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, o.pu, o.po, o.tos, e.pu, e.po, e.tos); end
    end
  endtask

  task automatic test_swap();
    rec_t e, o;
    do_reset();
    issue_op(OP_PUSHI, 16'd1);
    issue_op(OP_PUSHI, 16'd2);
    issue_op(OP_SWAP, 16'h0);
    issue_op(OP_POP, 16'h0);
    issue_op(OP_POP, 16'h0);
    for (int i = 0; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.res !== e.res) begin errors++; $display("[TB] FAIL swap_res[%0d]: got %h expected %h", i, o.res, e.res); end
      checks++; if (o.err !== e.err) begin errors++; $display("[TB] FAIL swap_err[%0d]: got %b expected %b", i, o.err, e.err); end
      checks++; if (o.depth !== e.depth) begin errors++; $display("[TB] FAIL swap_depth[%0d]: got %0d expected %0d", i, o.depth, e.depth); end
      checks++; if (o.lat != e.lat) begin errors++; $display("[TB] FAIL swap_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat); end
      checks++; if (o.pu != e.pu || o.po != e.po || o.tos != e.tos) begin errors++; $display("[TB] FAIL swap_strobes[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, o.pu, o.po, o.tos, e.pu, e.po, e.tos); end
    end
  endtask

  task automatic test_underflow_overflow();
    rec_t e, o;
    do_reset();
    issue_op(OP_ADD, 16'h0);
    issue_op(OP_PUSHI, 16'd9);
    issue_op(OP_POP, 16'h0);
    issue_op(OP_POP, 16'h0);
    issue_op(OP_NOT, 16'h0);
    for (int k = 0; k < 8; k++) issue_op(OP_PUSHI, 16'h0100 + 16'(k));
    issue_op(OP_DUP, 16'h0);
    issue_op(OP_PUSHI, 16'hAAAA);
    issue_op(OP_POP, 16'h0);
    issue_op(OP_DUP, 16'h0);
    for (int i = 0; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.res !== e.res) begin errors++; $display("[TB] FAIL bound_res[%0d]: got %h expected %h", i, o.res, e.res); end
      checks++; if (o.err !== e.err) begin errors++; $display("[TB] FAIL bound_err[%0d]: got %b expected %b", i, o.err, e.err); end
      checks++; if (o.depth !== e.depth) begin errors++; $display("[TB] FAIL bound_depth[%0d]: got %0d expected %0d", i, o.depth, e.depth); end
      checks++; if (o.lat != e.lat) begin errors++; $display("[TB] FAIL bound_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat); end
      checks++; if (o.pu != e.pu || o.po != e.po || o.tos != e.tos) begin errors++; $display("[TB] FAIL bound_strobes[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, o.pu, o.po, o.tos, e.pu, e.po, e.tos); end
    end
  endtask

  task automatic test_reset_mid_op();
    rec_t e, o;
    logic seen_done;
    do_reset();
    issue_op(OP_PUSHI, 16'd7);
    issue_op(OP_PUSHI, 16'd9);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_ADD;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rs.delete();
    exp_res = '0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.depth !== 4'd0) begin errors++; $display("[TB] FAIL midrst_depth: got %0d expected 0", bus.depth); end
    checks++; if ({bus.stk_push, bus.stk_pop, bus.stk_tos} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_strobes: got %b expected 000", {bus.stk_push, bus.stk_pop, bus.stk_tos}); end
    seen_done = bus.done;
    repeat (6) begin
      @(negedge clk);
      seen_done = seen_done | bus.done;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", seen_done); end
    issue_op(OP_PUSHI, 16'h0042);
    for (int i = 0; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.res !== e.res) begin errors++; $display("[TB] FAIL midrst_res[%0d]: got %h expected %h", i, o.res, e.res); end
      checks++; if (o.depth !== e.depth) begin errors++; $display("[TB] FAIL midrst_opdepth[%0d]: got %0d expected %0d", i, o.depth, e.depth); end
      checks++; if (o.lat != e.lat) begin errors++; $display("[TB] FAIL midrst_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat); end
    end
    // Still in the DONE cycle here: a start raised now must be ignored.
    bus.start = 1'b1;
    bus.op = OP_POP;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL done_start_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.depth !== 4'd1) begin errors++; $display("[TB] FAIL done_start_depth: got %0d expected 1", bus.depth); end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      issue_op((k < 4) ? OP_PUSHI : 3'($urandom_range(0, 7)), 16'($urandom));
    end
    for (int i = 0; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.res !== e.res) begin errors++; $display("[TB] FAIL b2b_res[%0d]: got %h expected %h", i, o.res, e.res); end
      checks++; if (o.err !== e.err) begin errors++; $display("[TB] FAIL b2b_err[%0d]: got %b expected %b", i, o.err, e.err); end
      checks++; if (o.depth !== e.depth) begin errors++; $display("[TB] FAIL b2b_depth[%0d]: got %0d expected %0d", i, o.depth, e.depth); end
      checks++; if (o.lat != e.lat) begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat); end
      checks++; if (o.pu != e.pu || o.po != e.po || o.tos != e.tos) begin errors++; $display("[TB] FAIL b2b_strobes[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, o.pu, o.po, o.tos, e.pu, e.po, e.tos); end
    end
    checks++; if (n_multi != 0) begin errors++; $display("[TB] FAIL one_strobe: got %0d overlapping cycles expected 0", n_multi); end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.imm = '0;
    exp_res = '0;
    test_reset();
    test_add();
    test_sub_not();
    test_swap();
    test_underflow_overflow();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
